// File: rtl/store_retire_buffer.sv
// Store retire buffer: FIFO of committed stores draining one per cycle to the
// dcache, with a registered per-write acknowledge and a store-to-load forward
// lookup over pending entries.
module store_retire_buffer #(
    parameter int unsigned N_WAY = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned POS_W = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_WAY-1:0]         i_ret_valid,
    input  logic [N_WAY*XLEN-1:0]    i_ret_address,
    input  logic [N_WAY*XLEN-1:0]    i_ret_data,
    input  logic [N_WAY*2-1:0]       i_ret_size,
    input  logic [N_WAY*POS_W-1:0]   i_ret_store_pos,
    output logic [$clog2(DEPTH):0]   o_free_count,
    output logic                     o_dc_req_valid,
    output logic [XLEN-1:0]          o_dc_req_address,
    output logic [XLEN-1:0]          o_dc_req_data,
    output logic [1:0]               o_dc_req_size,
    input  logic                     i_dc_req_ready,
    output logic                     o_ack_valid,
    output logic [XLEN-1:0]          o_ack_address,
    output logic [POS_W-1:0]         o_ack_store_pos,
    input  logic                     i_ld_valid,
    input  logic [XLEN-1:0]          i_ld_address,
    input  logic [1:0]               i_ld_size,
    output logic                     o_fwd_hit,
    output logic [XLEN-1:0]          o_fwd_data,
    output logic                     o_overflow_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Entry storage (not reset: contents are meaningless outside head..tail)
    logic [XLEN-1:0]  r_addr [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic [POS_W-1:0] r_pos  [DEPTH];

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_free_count;
    logic             r_ack_valid;
    logic [XLEN-1:0]  r_ack_address;
    logic [POS_W-1:0] r_ack_pos;
    logic             r_overflow;

    logic [CW-1:0]    w_space;
    logic [CW-1:0]    w_n_acc;
    logic [CW-1:0]    w_count_next;
    logic [N_WAY-1:0] w_acc;
    logic [AW-1:0]    w_wr_idx [N_WAY];
    logic             w_drop;
    logic             w_pop;
    logic [AW-1:0]    w_fwd_idx;
    logic             w_fwd_hit;
    logic [XLEN-1:0]  w_fwd_data;

    // Lane acceptance against pre-pop occupancy; accepted lanes are packed at tail
    always_comb begin
        w_space = CW'(DEPTH) - r_count;
        w_n_acc = '0;
        w_drop  = 1'b0;
        for (int k = 0; k < N_WAY; k++) begin
            w_wr_idx[k] = r_tail + w_n_acc[AW-1:0];
            w_acc[k]    = i_ret_valid[k] && (CW'(k) < w_space);
            if (w_acc[k]) begin
                w_n_acc = w_n_acc + CW'(1);
            end else if (i_ret_valid[k]) begin
                w_drop = 1'b1;
            end
        end
    end

    assign w_pop        = (r_count != '0) && i_dc_req_ready;
    assign w_count_next = r_count + w_n_acc - CW'(w_pop);

    // Pointer, occupancy, ack and sticky overflow state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_free_count  <= CW'(DEPTH);
            r_ack_valid   <= 1'b0;
            r_ack_address <= '0;
            r_ack_pos     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_tail       <= r_tail + w_n_acc[AW-1:0];
            r_count      <= w_count_next;
            r_free_count <= CW'(DEPTH) - w_count_next;
            r_overflow   <= r_overflow | w_drop;
            r_ack_valid  <= w_pop;
            if (w_pop) begin
                r_head        <= r_head + AW'(1);
                r_ack_address <= r_addr[r_head];
                r_ack_pos     <= r_pos[r_head];
            end
        end
    end

    // Write accepted lanes into the entry array
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < N_WAY; k++) begin
            if (w_acc[k]) begin
                r_addr[w_wr_idx[k]] <= i_ret_address[k*XLEN +: XLEN];
                r_data[w_wr_idx[k]] <= i_ret_data[k*XLEN +: XLEN];
                r_size[w_wr_idx[k]] <= i_ret_size[k*2 +: 2];
                r_pos[w_wr_idx[k]]  <= i_ret_store_pos[k*POS_W +: POS_W];
            end
        end
    end

    // Forward lookup: scan oldest to youngest so the youngest exact match wins
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + AW'(i);
            if (i_ld_valid && (CW'(i) < r_count) && (r_size[w_fwd_idx] == i_ld_size) &&
                (r_addr[w_fwd_idx] == i_ld_address)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_fwd_idx];
            end
        end
    end

    assign o_free_count     = r_free_count;
    assign o_dc_req_valid   = (r_count != '0);
    assign o_dc_req_address = r_addr[r_head];
    assign o_dc_req_data    = r_data[r_head];
    assign o_dc_req_size    = r_size[r_head];
    assign o_ack_valid      = r_ack_valid;
    assign o_ack_address    = r_ack_address;
    assign o_ack_store_pos  = r_ack_pos;
    assign o_fwd_hit        = w_fwd_hit;
    assign o_fwd_data       = w_fwd_data;
    assign o_overflow_err   = r_overflow;
endmodule

// File: tb/tb_store_retire_buffer.sv
// Scoreboard bench for store_retire_buffer: a queue model of pending entries
// predicts dc_req, ack, free_count, overflow and forward results.
module tb_store_retire_buffer;
    localparam int N_WAY = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int POS_W = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [1:0]       size;
        logic [POS_W-1:0] pos;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_WAY-1:0]       ret_valid;
    logic [N_WAY*XLEN-1:0]  ret_address;
    logic [N_WAY*XLEN-1:0]  ret_data;
    logic [N_WAY*2-1:0]     ret_size;
    logic [N_WAY*POS_W-1:0] ret_store_pos;
    logic [CW-1:0]          free_count;
    logic                   dc_req_valid;
    logic [XLEN-1:0]        dc_req_address;
    logic [XLEN-1:0]        dc_req_data;
    logic [1:0]             dc_req_size;
    logic                   dc_req_ready;
    logic                   ack_valid;
    logic [XLEN-1:0]        ack_address;
    logic [POS_W-1:0]       ack_store_pos;
    logic                   ld_valid;
    logic [XLEN-1:0]        ld_address;
    logic [1:0]             ld_size;
    logic                   fwd_hit;
    logic [XLEN-1:0]        fwd_data;
    logic                   overflow_err;

    ent_t            sb[$];
    ent_t            lane[N_WAY];
    bit              m_ovf;
    logic [XLEN-1:0] m_ack_addr;
    logic [POS_W-1:0] m_ack_pos;
    int              n_tests;
    int              n_fail;

    store_retire_buffer #(
        .N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN), .POS_W(POS_W)
    ) u_dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_ret_valid     (ret_valid),
        .i_ret_address   (ret_address),
        .i_ret_data      (ret_data),
        .i_ret_size      (ret_size),
        .i_ret_store_pos (ret_store_pos),
        .o_free_count    (free_count),
        .o_dc_req_valid  (dc_req_valid),
        .o_dc_req_address(dc_req_address),
        .o_dc_req_data   (dc_req_data),
        .o_dc_req_size   (dc_req_size),
        .i_dc_req_ready  (dc_req_ready),
        .o_ack_valid     (ack_valid),
        .o_ack_address   (ack_address),
        .o_ack_store_pos (ack_store_pos),
        .i_ld_valid      (ld_valid),
        .i_ld_address    (ld_address),
        .i_ld_size       (ld_size),
        .o_fwd_hit       (fwd_hit),
        .o_fwd_data      (fwd_data),
        .o_overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                            input logic [1:0] s, input logic [POS_W-1:0] p);
        lane[k] = '{addr: a, data: d, size: s, pos: p};
    endtask

    // One cycle: drive at negedge, check comb outputs, update model, check after posedge
    task automatic step(input logic [N_WAY-1:0] v, input logic rdy);
        ent_t            popped;
        bit              pop;
        bit              hit;
        logic [XLEN-1:0] fd;
        int              base;
        ret_valid    = v;
        dc_req_ready = rdy;
        for (int k = 0; k < N_WAY; k++) begin
            ret_address[k*XLEN +: XLEN]     = lane[k].addr;
            ret_data[k*XLEN +: XLEN]        = lane[k].data;
            ret_size[k*2 +: 2]              = lane[k].size;
            ret_store_pos[k*POS_W +: POS_W] = lane[k].pos;
        end
        #1;
        check_eq("req_valid", dc_req_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            check_eq("req_addr", dc_req_address, sb[0].addr);
            check_eq("req_data", dc_req_data, sb[0].data);
            check_eq("req_size", dc_req_size, sb[0].size);
        end
        hit = 1'b0;
        fd  = '0;
        if (ld_valid) begin
            foreach (sb[i]) begin
                if (sb[i].size == ld_size && sb[i].addr == ld_address) begin
                    hit = 1'b1;
                    fd  = sb[i].data;
                end
            end
        end
        check_eq("fwd_hit", fwd_hit, hit);
        check_eq("fwd_data", fwd_data, fd);
        pop  = (sb.size() != 0) && rdy;
        base = sb.size();
        if (pop) popped = sb.pop_front();
        for (int k = 0; k < N_WAY; k++) begin
            if (v[k]) begin
                if (k < DEPTH - base) sb.push_back(lane[k]);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("ack_valid", ack_valid, pop);
        if (pop) begin
            m_ack_addr = popped.addr;
            m_ack_pos  = popped.pos;
        end
        check_eq("ack_addr", ack_address, m_ack_addr);
        check_eq("ack_pos", ack_store_pos, m_ack_pos);
        check_eq("free_count", free_count, DEPTH - sb.size());
        check_eq("overflow", overflow_err, m_ovf);
        @(negedge clk);
        ret_valid = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ovf   = 1'b0;
        m_ack_addr = '0;
        m_ack_pos  = '0;
        rst = 1'b1;
        ret_valid = '0; ret_address = '0; ret_data = '0; ret_size = '0; ret_store_pos = '0;
        dc_req_ready = 1'b0; ld_valid = 1'b0; ld_address = '0; ld_size = '0;
        for (int k = 0; k < N_WAY; k++) set_lane(k, '0, '0, 2'd0, '0);
        #12;
        check_eq("rst_req_valid", dc_req_valid, 1'b0);
        check_eq("rst_free", free_count, DEPTH);
        check_eq("rst_ack_valid", ack_valid, 1'b0);
        check_eq("rst_ack_addr", ack_address, 0);
        check_eq("rst_ack_pos", ack_store_pos, 0);
        check_eq("rst_ovf", overflow_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic two-lane retire and drain
        set_lane(0, 32'h100, 32'hAA, 2'd2, 4'd1);
        set_lane(1, 32'h104, 32'hBB, 2'd2, 4'd2);
        step(2'b11, 1'b1);
        repeat (3) step(2'b00, 1'b1);

        // Fill with ready low, then overflow
        for (int c = 0; c < 5; c++) begin
            set_lane(0, 32'h400 + 32'(c * 8), 32'h1000 + 32'(c), 2'd2, 4'(2 * c + 1));
            set_lane(1, 32'h404 + 32'(c * 8), 32'h2000 + 32'(c), 2'd1, 4'(2 * c + 2));
            step(2'b11, 1'b0);
        end
        // Full: single lane dropped while a pop proceeds
        set_lane(0, 32'h500, 32'h55, 2'd0, 4'd9);
        step(2'b01, 1'b1);
        repeat (8) step(2'b00, 1'b1);

        // Wrap: 7 pushes, 7 pops, 3 pushes, drain
        for (int c = 0; c < 10; c++) begin
            set_lane(0, 32'h600 + 32'(c * 4), 32'hC0DE0000 + 32'(c), 2'(c % 3), 4'(c + 1));
            step(2'b01, 1'b0);
            if (c == 6) repeat (7) step(2'b00, 1'b1);
        end
        repeat (4) step(2'b00, 1'b1);

        // Forward: same-cycle enqueues invisible, youngest match wins, size must match
        ld_valid = 1'b1; ld_address = 32'h200; ld_size = 2'd2;
        set_lane(0, 32'h200, 32'h11, 2'd2, 4'd1);
        set_lane(1, 32'h200, 32'h22, 2'd2, 4'd2);
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        ld_size = 2'd1;
        step(2'b00, 1'b0);
        ld_valid = 1'b0; ld_size = 2'd2;
        set_lane(0, 32'h210, 32'h33, 2'd2, 4'd3);
        step(2'b01, 1'b0);

        // Asynchronous reset with three entries pending
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req_valid", dc_req_valid, 1'b0);
        check_eq("arst_free", free_count, DEPTH);
        check_eq("arst_ack_valid", ack_valid, 1'b0);
        sb.delete();
        m_ovf = 1'b0;
        m_ack_addr = '0;
        m_ack_pos  = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(2'b00, 1'b1);

        // Randomised traffic with forward queries on a small address set
        for (int c = 0; c < 60; c++) begin
            logic [N_WAY-1:0] v;
            int n;
            n = $urandom_range(0, 2);
            v = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            for (int k = 0; k < N_WAY; k++)
                set_lane(k, 32'h300 + 32'($urandom_range(0, 2) * 4), $urandom,
                         2'($urandom_range(0, 2)), 4'($urandom_range(1, 15)));
            ld_valid   = 1'($urandom_range(0, 1));
            ld_address = 32'h300 + 32'($urandom_range(0, 2) * 4);
            ld_size    = 2'($urandom_range(0, 2));
            step(v, 1'($urandom_range(0, 1)));
        end
        ld_valid = 1'b0;
        repeat (DEPTH + 1) step(2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
